// File: rtl/bus_pkg.sv
// Shared register-bus definitions: FSM state encoding, width helpers and the
// all-ones read value returned on error. Used by the fabric, the SPI master
// and the register slaves.
package bus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Read value reported for unmapped slaves and ack timeouts; slice to DW.
  localparam logic [63:0] ERR_RDATA = '1;

  // Slave index width: the address bits above the slave-local field.
  function automatic int idx_width(input int aw, input int saw);
    return aw - saw;
  endfunction

  // Timeout counter width; a zero TIMEOUT still gets a 1-bit counter.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bus_rdata_sel.sv
// Registers the slave index of the accepted request and uses it to pick
// that slave's ack bit and read-data lane out of the packed input vectors.
// The mux itself is combinational so an ack is seen in the cycle it arrives.
module bus_rdata_sel #(
  parameter int NSLV = 4,
  parameter int DW   = 8,
  parameter int IW   = 2
) (
  input  logic               i_clk,
  input  logic               i_load,
  input  logic [IW-1:0]      i_idx,
  input  logic [NSLV-1:0]    i_ack,
  input  logic [NSLV*DW-1:0] i_rdata,
  output logic               o_ack,
  output logic [DW-1:0]      o_rdata
);

  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;

  assign idx_d = i_load ? i_idx : idx_q;

  // Hold the index for the whole access; it is only meaningful while WAIT.
  always_ff @(posedge i_clk) begin
    idx_q <= idx_d;
  end

  // Select the addressed slave's ack and data lane; unmapped index yields 0.
  always_comb begin
    o_ack   = 1'b0;
    o_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (idx_q == IW'(k)) begin
        o_ack   = i_ack[k];
        o_rdata = i_rdata[k*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Register-bus interconnect between the SPI master and NSLV register slaves.
// Decodes the slave index from the upper address bits, drives a one-hot
// select with a one-cycle read/write strobe, waits for the slave's ack (or a
// timeout) and reports completion with a one-cycle done pulse.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int NSLV    = 4,
  parameter int AW      = 7,
  parameter int SAW     = 5,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_req,
  input  logic               i_wr,
  input  logic [AW-1:0]      i_addr,
  input  logic [DW-1:0]      i_wdata,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [DW-1:0]      o_rdata,
  output logic [NSLV-1:0]    o_sel,
  output logic [SAW-1:0]     o_addr,
  output logic [DW-1:0]      o_wdata,
  output logic               o_wr_req,
  output logic               o_rd_req,
  input  logic [NSLV-1:0]    i_ack,
  input  logic [NSLV*DW-1:0] i_rdata
);

  localparam int IW = idx_width(AW, SAW);
  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [DW-1:0] ERR_DATA = ERR_RDATA[DW-1:0];

  logic [1:0]      state_q,  state_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic            wr_q,     wr_d;
  logic [NSLV-1:0] sel_q,    sel_d;
  logic [SAW-1:0]  addr_q,   addr_d;
  logic [DW-1:0]   wdata_q,  wdata_d;
  logic            wr_req_q, wr_req_d;
  logic            rd_req_q, rd_req_d;
  logic            done_q,   done_d;
  logic            err_q,    err_d;
  logic [DW-1:0]   rdata_q,  rdata_d;

  logic [IW-1:0]   req_idx;
  logic            req_mapped;
  logic [NSLV-1:0] req_sel;
  logic            idx_load;
  logic            ack_hit;
  logic [DW-1:0]   ack_data;

  assign req_idx    = i_addr[AW-1:SAW];
  assign req_mapped = (int'(req_idx) < NSLV);
  assign idx_load   = (state_q == ST_IDLE) && i_req;

  // One-hot decode of the requested slave index.
  always_comb begin
    req_sel = '0;
    for (int k = 0; k < NSLV; k++) begin
      req_sel[k] = (req_idx == IW'(k));
    end
  end

  bus_rdata_sel #(
    .NSLV (NSLV),
    .DW   (DW),
    .IW   (IW)
  ) u_rdata_sel (
    .i_clk   (i_clk),
    .i_load  (idx_load),
    .i_idx   (req_idx),
    .i_ack   (i_ack),
    .i_rdata (i_rdata),
    .o_ack   (ack_hit),
    .o_rdata (ack_data)
  );

  // Transaction FSM next-state: accept in IDLE, wait for ack/timeout, pulse done.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_req_d = 1'b0;
    rd_req_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          wr_d = i_wr;
          if (req_mapped) begin
            state_d  = ST_WAIT;
            sel_d    = req_sel;
            addr_d   = i_addr[SAW-1:0];
            wdata_d  = i_wdata;
            wr_req_d = i_wr;
            rd_req_d = !i_wr;
            cnt_d    = CW'(1);
          end else begin
            // Unmapped slave: skip WAIT and complete with an error.
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            if (!i_wr) rdata_d = ERR_DATA;
          end
        end
      end

      ST_WAIT: begin
        if (ack_hit) begin
          // An ack on the terminal count still wins over the timeout.
          state_d = ST_DONE;
          sel_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (!wr_q) rdata_d = ack_data;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT))) begin
          state_d = ST_DONE;
          sel_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          if (!wr_q) rdata_d = ERR_DATA;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything and drops any access.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_busy   = (state_q != ST_IDLE);
  assign o_done   = done_q;
  assign o_err    = err_q;
  assign o_rdata  = rdata_q;
  assign o_sel    = sel_q;
  assign o_addr   = addr_q;
  assign o_wdata  = wdata_q;
  assign o_wr_req = wr_req_q;
  assign o_rd_req = rd_req_q;

endmodule
